// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction ROM bus and
// IF/ID pipeline register outputs. The slave modport is the fetch stage's
// view; the master modport is the surrounding pipeline / ROM.
interface if_stage_if;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        inst_rom_ce;
  logic [31:0] inst_rom_addr;
  logic [31:0] inst_rom_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  modport master (
    output stall, branch_flag_i, branch_target_address_i, inst_rom_data,
    input  inst_rom_ce, inst_rom_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    input  stall, branch_flag_i, branch_target_address_i, inst_rom_data,
    output inst_rom_ce, inst_rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction ROM drive and the
// IF/ID pipeline register. Branches use a delay slot, so nothing is flushed.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.slave   bus
);

  logic        ce_q,       ce_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_inst_q,  id_inst_d;
  logic        id_valid_q, id_valid_d;

  // Stall bits above the IF/ID pair belong to later stages.
  logic unused_stall_hi;
  assign unused_stall_hi = ^bus.stall[5:3];

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Next-state: startup forcing, PC priority (stall > branch > step) and
  // IF/ID priority (bubble > hold > load).
  always_comb begin
    ce_d       = 1'b1;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;

    if (!ce_q) begin
      pc_d       = RESET_PC;
      id_pc_d    = 32'd0;
      id_inst_d  = 32'd0;
      id_valid_d = 1'b0;
    end else begin
      if (bus.stall[0]) begin
        pc_d = pc_q;
      end else if (bus.branch_flag_i) begin
        pc_d = align_word(bus.branch_target_address_i);
      end else begin
        pc_d = pc_q + PC_STEP;
      end

      if (bus.stall[1] && !bus.stall[2]) begin
        id_pc_d    = 32'd0;
        id_inst_d  = 32'd0;
        id_valid_d = 1'b0;
      end else if (bus.stall[1]) begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
      end else begin
        id_pc_d    = pc_q;
        id_inst_d  = bus.inst_rom_data;
        id_valid_d = 1'b1;
      end
    end
  end

  // State registers; active-low synchronous reset wins over stall and branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ce_q       <= 1'b0;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      ce_q       <= ce_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.inst_rom_ce   = ce_q;
  assign bus.inst_rom_addr = pc_q;
  assign bus.id_pc         = id_pc_q;
  assign bus.id_inst       = id_inst_q;
  assign bus.id_valid      = id_valid_q;

endmodule
